// File: rtl/udp_rx_pkg.sv
// Shared types and constants for the UDP receive frame controller.
package udp_rx_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_DROP,
        S_COMMIT
    } state_t;

    localparam int unsigned UDP_HDR_LEN = 8;
    localparam int unsigned DESC_DEPTH  = 2;
    localparam int unsigned LEN_W       = 16;
    localparam int unsigned IP_W        = 32;
    localparam int unsigned PORT_W      = 16;

    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [IP_W-1:0]   src_addr;
        logic [PORT_W-1:0] src_port;
    } desc_t;

endpackage

// File: rtl/udp_rx_buf_ram.sv
// Simple dual-port payload byte RAM: one write port, one registered read port.
module udp_rx_buf_ram #(
    parameter int unsigned AW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the output register is reset so the visible read data clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/udp_rx_frame_ctrl.sv
// Receive frame controller: buffers accepted UDP payloads in a byte ring and
// hands completed frames to a single consumer via a 2-entry descriptor FIFO.
module udp_rx_frame_ctrl
    import udp_rx_pkg::*;
#(
    parameter int unsigned AW      = 11,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_update,
    input  logic [7:0]  rx_data,
    input  logic [15:0] rx_udp_len,
    input  logic [31:0] rx_src_addr,
    input  logic [15:0] rx_src_port,
    output logic        frm_valid,
    output logic [15:0] frm_len,
    output logic [31:0] frm_src_addr,
    output logic [15:0] frm_src_port,
    input  logic        rd_en,
    output logic [7:0]  rd_data,
    output logic        rd_vld,
    output logic [15:0] drop_cnt,
    output logic        abort_pulse
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned GW    = $clog2(TIMEOUT + 1);

    state_t        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, start_q, start_d;
    logic [AW:0]   used_q, used_d, used_abort;
    logic [15:0]   cnt_q, cnt_d, plen_q, plen_d, popped_q, popped_d;
    logic [31:0]   src_addr_q, src_addr_d;
    logic [15:0]   src_port_q, src_port_d, drop_cnt_q, drop_cnt_d;
    logic          bad_q, bad_d, abort_q, abort_d, rd_vld_q;
    logic [GW-1:0] gap_q, gap_d;
    logic          head_q, tail_q;
    logic [1:0]    dcnt_q, dcnt_eff;
    desc_t         desc_q [DESC_DEPTH];
    desc_t         head_desc;

    logic [15:0] new_plen;
    logic [16:0] avail;
    logic        new_bad, new_ok, timeout, wr_en, push, rd_fire, retire;

    assign new_plen = rx_udp_len - 16'(UDP_HDR_LEN);
    assign new_bad  = (rx_udp_len < 16'(UDP_HDR_LEN + 1)) || ({1'b0, new_plen} > 17'(DEPTH));
    assign avail    = 17'(DEPTH) - 17'(used_q);
    // A descriptor being pushed this cycle already occupies a FIFO slot.
    assign push     = (state_q == S_COMMIT);
    assign dcnt_eff = dcnt_q + {1'b0, push};
    assign new_ok   = !new_bad && ({1'b0, new_plen} <= avail) && (dcnt_eff < 2'(DESC_DEPTH));
    assign timeout  = (gap_q == GW'(TIMEOUT - 1)) && !rx_update;

    assign head_desc    = desc_q[head_q];
    assign frm_valid    = (dcnt_q != 2'd0);
    assign frm_len      = frm_valid ? head_desc.len : '0;
    assign frm_src_addr = frm_valid ? head_desc.src_addr : '0;
    assign frm_src_port = frm_valid ? head_desc.src_port : '0;
    assign rd_fire      = rd_en && frm_valid;
    assign retire       = rd_fire && (popped_q + 16'd1 == frm_len);
    assign rd_vld       = rd_vld_q;
    assign drop_cnt     = drop_cnt_q;
    assign abort_pulse  = abort_q;

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        start_d    = start_q;
        cnt_d      = cnt_q;
        plen_d     = plen_q;
        src_addr_d = src_addr_q;
        src_port_d = src_port_q;
        bad_d      = bad_q;
        drop_cnt_d = drop_cnt_q;
        gap_d      = '0;
        wr_en      = 1'b0;
        abort_d    = 1'b0;
        used_abort = '0;
        unique case (state_q)
            S_IDLE, S_COMMIT: begin
                state_d = S_IDLE;
                if (rx_update) begin
                    plen_d     = new_plen;
                    src_addr_d = rx_src_addr;
                    src_port_d = rx_src_port;
                    bad_d      = new_bad;
                    cnt_d      = 16'd1;
                    if (new_ok) begin
                        start_d = wptr_q;
                        wr_en   = 1'b1;
                        wptr_d  = wptr_q + AW'(1);
                        state_d = (new_plen == 16'd1) ? S_COMMIT : S_WRITE;
                    end else begin
                        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
                        state_d = (new_plen == 16'd1) ? S_IDLE : S_DROP;
                    end
                end
            end
            S_WRITE: begin
                if (rx_update) begin
                    wr_en  = 1'b1;
                    wptr_d = wptr_q + AW'(1);
                    cnt_d  = cnt_q + 16'd1;
                    if (cnt_q + 16'd1 == plen_q) state_d = S_COMMIT;
                end else if (timeout) begin
                    wptr_d     = start_q;
                    used_abort = cnt_q[AW:0];
                    abort_d    = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            S_DROP: begin
                // Bad-length frames have no usable count; only the timeout ends them.
                if (rx_update) begin
                    if (!bad_q) begin
                        cnt_d = cnt_q + 16'd1;
                        if (cnt_q + 16'd1 == plen_q) state_d = S_IDLE;
                    end
                end else if (timeout) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign used_d   = used_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_fire} - used_abort;
    assign rptr_d   = rd_fire ? rptr_q + AW'(1) : rptr_q;
    assign popped_d = retire ? 16'd0 : (rd_fire ? popped_q + 16'd1 : popped_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            start_q    <= '0;
            used_q     <= '0;
            cnt_q      <= '0;
            plen_q     <= '0;
            src_addr_q <= '0;
            src_port_q <= '0;
            bad_q      <= 1'b0;
            drop_cnt_q <= '0;
            gap_q      <= '0;
            abort_q    <= 1'b0;
            rd_vld_q   <= 1'b0;
            popped_q   <= '0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            dcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            start_q    <= start_d;
            used_q     <= used_d;
            cnt_q      <= cnt_d;
            plen_q     <= plen_d;
            src_addr_q <= src_addr_d;
            src_port_q <= src_port_d;
            bad_q      <= bad_d;
            drop_cnt_q <= drop_cnt_d;
            gap_q      <= gap_d;
            abort_q    <= abort_d;
            rd_vld_q   <= rd_fire;
            popped_q   <= popped_d;
            head_q     <= head_q ^ retire;
            tail_q     <= tail_q ^ push;
            dcnt_q     <= dcnt_q + {1'b0, push} - {1'b0, retire};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            desc_q[tail_q] <= '{len: plen_q, src_addr: src_addr_q, src_port: src_port_q};
        end
    end

    udp_rx_buf_ram #(
        .AW(AW)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .we   (wr_en),
        .waddr(wptr_q),
        .wdata(rx_data),
        .re   (rd_fire),
        .raddr(rptr_q),
        .rdata(rd_data)
    );

endmodule

// File: tb/tb_udp_rx_frame_ctrl.sv
// Bench for udp_rx_frame_ctrl: table vectors, directed corner sequences and
// randomized frames checked against a frame-level reference model.
module tb_udp_rx_frame_ctrl;

    localparam int unsigned AW      = 4;
    localparam int unsigned TIMEOUT = 32;
    localparam int          DEPTH   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_update = 1'b0;
    logic [7:0]  rx_data = '0;
    logic [15:0] rx_udp_len = '0;
    logic [31:0] rx_src_addr = '0;
    logic [15:0] rx_src_port = '0;
    logic        rd_en = 1'b0;
    logic        frm_valid, rd_vld, abort_pulse;
    logic [15:0] frm_len, frm_src_port, drop_cnt;
    logic [31:0] frm_src_addr;
    logic [7:0]  rd_data;

    int checks = 0;
    int failures = 0;
    bit rand_rd = 1'b0;

    udp_rx_frame_ctrl #(
        .AW(AW),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .rx_update(rx_update), .rx_data(rx_data),
        .rx_udp_len(rx_udp_len), .rx_src_addr(rx_src_addr), .rx_src_port(rx_src_port),
        .frm_valid(frm_valid), .frm_len(frm_len), .frm_src_addr(frm_src_addr),
        .frm_src_port(frm_src_port), .rd_en(rd_en), .rd_data(rd_data), .rd_vld(rd_vld),
        .drop_cnt(drop_cnt), .abort_pulse(abort_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: frames as byte queues, descriptors as a queue of records.
    typedef struct {
        int          len;
        logic [31:0] addr;
        logic [15:0] port;
    } mdesc_t;

    logic [7:0] m_fifo[$];
    logic [7:0] m_cur[$];
    mdesc_t     m_desc[$];
    mdesc_t     m_cur_d;
    int         m_mode;  // 0 waiting for a frame, 1 storing, 2 skipping
    bit         m_pending, m_bad, e_abort, e_vld;
    int         m_plen, m_cnt, m_gap, m_popped, m_drop;
    logic [7:0] e_data;

    task automatic model_step();
        int used_pre, dcnt_pre, plen;
        bit bad;
        if (rst) begin
            m_fifo.delete(); m_cur.delete(); m_desc.delete();
            m_mode = 0; m_pending = 0; m_gap = 0; m_popped = 0; m_drop = 0;
            e_abort = 0; e_vld = 0; e_data = '0;
            return;
        end
        used_pre = m_fifo.size() + m_cur.size();
        dcnt_pre = m_desc.size() + int'(m_pending);
        e_abort = 0;
        e_vld = 0;
        if (rd_en && m_desc.size() > 0) begin
            e_vld = 1;
            e_data = m_fifo.pop_front();
            m_popped++;
            if (m_popped == m_desc[0].len) begin
                m_desc.delete(0);
                m_popped = 0;
            end
        end
        if (m_pending) begin
            m_desc.push_back(m_cur_d);
            foreach (m_cur[i]) m_fifo.push_back(m_cur[i]);
            m_cur.delete();
            m_pending = 0;
        end
        if (m_mode == 0) begin
            if (rx_update) begin
                plen = int'(rx_udp_len) - 8;
                bad = (rx_udp_len < 16'd9) || (plen > DEPTH);
                m_gap = 0;
                if (!bad && plen <= DEPTH - used_pre && dcnt_pre < 2) begin
                    m_cur.push_back(rx_data);
                    m_cur_d = '{plen, rx_src_addr, rx_src_port};
                    m_plen = plen;
                    if (plen == 1) m_pending = 1;
                    else m_mode = 1;
                end else begin
                    if (m_drop < 65535) m_drop++;
                    m_bad = bad;
                    m_plen = plen;
                    m_cnt = 1;
                    if (bad || plen != 1) m_mode = 2;
                end
            end
        end else if (rx_update) begin
            m_gap = 0;
            if (m_mode == 1) begin
                m_cur.push_back(rx_data);
                if (m_cur.size() == m_plen) begin
                    m_mode = 0;
                    m_pending = 1;
                end
            end else begin
                m_cnt++;
                if (!m_bad && m_cnt == m_plen) m_mode = 0;
            end
        end else begin
            m_gap++;
            if (m_gap == TIMEOUT) begin
                if (m_mode == 1) begin
                    m_cur.delete();
                    e_abort = 1;
                end
                m_mode = 0;
            end
        end
    endtask

    task automatic model_check();
        bit fv;
        fv = (m_desc.size() > 0);
        chk("model_frm_valid", frm_valid, fv);
        chk("model_frm_len", frm_len, fv ? m_desc[0].len : 0);
        if (fv) begin
            chk("model_frm_src_addr", frm_src_addr, m_desc[0].addr);
            chk("model_frm_src_port", frm_src_port, m_desc[0].port);
        end
        chk("model_rd_vld", rd_vld, e_vld);
        if (e_vld) chk("model_rd_data", rd_data, e_data);
        chk("model_drop_cnt", drop_cnt, m_drop);
        chk("model_abort_pulse", abort_pulse, e_abort);
    endtask

    task automatic tick();
        if (rand_rd) rd_en = ($urandom_range(0, 2) != 0);
        @(posedge clk);
        model_step();
        #1;
        model_check();
    endtask

    task automatic idle(input int n);
        rx_update = 1'b0;
        rd_en = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_update = 1'b0;
        rd_en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic send_bytes(input logic [15:0] len, input logic [31:0] addr,
                              input logic [15:0] port, input logic [7:0] base, input int n);
        rx_udp_len = len;
        rx_src_addr = addr;
        rx_src_port = port;
        for (int i = 0; i < n; i++) begin
            rx_update = 1'b1;
            rx_data = base + 8'(i);
            tick();
        end
        rx_update = 1'b0;
    endtask

    task automatic pop_frame(input int n, input logic [7:0] base, input string nm);
        logic [7:0] e;
        for (int i = 0; i < n; i++) begin
            rd_en = 1'b1;
            tick();
            e = base + 8'(i);
            chk({nm, "_rd_vld"}, rd_vld, 1'b1);
            chk({nm, "_rd_data"}, rd_data, e);
        end
        rd_en = 1'b0;
    endtask

    typedef struct {
        bit         upd;
        logic [7:0] d;
        bit         rd;
        bit         fv;
        logic [15:0] len;
        bit         vld;
        logic [7:0] rdd;
    } vec_t;

    vec_t tv[10];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        int hits, seen_at, kind, plen, nb;
        tv[0] = '{1, 8'd11, 0, 0, 16'd0, 0, 8'd0};
        tv[1] = '{1, 8'd22, 0, 0, 16'd0, 0, 8'd0};
        tv[2] = '{1, 8'd33, 0, 0, 16'd0, 0, 8'd0};
        tv[3] = '{1, 8'd44, 0, 0, 16'd0, 0, 8'd0};
        tv[4] = '{0, 8'd0,  0, 1, 16'd4, 0, 8'd0};
        tv[5] = '{0, 8'd0,  1, 1, 16'd4, 1, 8'd11};
        tv[6] = '{0, 8'd0,  1, 1, 16'd4, 1, 8'd22};
        tv[7] = '{0, 8'd0,  1, 1, 16'd4, 1, 8'd33};
        tv[8] = '{0, 8'd0,  1, 0, 16'd0, 1, 8'd44};
        tv[9] = '{0, 8'd0,  1, 0, 16'd0, 0, 8'd0};

        do_reset();
        chk("reset_frm_valid", frm_valid, 1'b0);
        chk("reset_rd_data", rd_data, 8'd0);
        chk("reset_drop_cnt", drop_cnt, 16'd0);

        // Basic frame from 192.168.0.5:5000.
        rx_udp_len = 16'd12;
        rx_src_addr = 32'hC0A8_0005;
        rx_src_port = 16'd5000;
        foreach (tv[i]) begin
            rx_update = tv[i].upd;
            rx_data = tv[i].d;
            rd_en = tv[i].rd;
            tick();
            chk("t1_frm_valid", frm_valid, tv[i].fv);
            chk("t1_frm_len", frm_len, tv[i].len);
            chk("t1_rd_vld", rd_vld, tv[i].vld);
            if (tv[i].vld) chk("t1_rd_data", rd_data, tv[i].rdd);
            if (tv[i].fv) begin
                chk("t1_src_addr", frm_src_addr, 32'hC0A8_0005);
                chk("t1_src_port", frm_src_port, 16'd5000);
            end
        end

        // No space: B dropped, A intact; B' then wraps across address 15->0.
        do_reset();
        send_bytes(16'd18, 32'h0A00_0001, 16'd100, 8'h01, 10);
        idle(1);
        send_bytes(16'd16, 32'h0A00_0002, 16'd200, 8'h40, 8);
        idle(1);
        chk("t2_drop_cnt", drop_cnt, 16'd1);
        chk("t2_a_len", frm_len, 16'd10);
        chk("t2_a_port", frm_src_port, 16'd100);
        pop_frame(10, 8'h01, "t2_a");
        chk("t2_empty", frm_valid, 1'b0);
        send_bytes(16'd16, 32'h0A00_0003, 16'd300, 8'h50, 8);
        idle(1);
        chk("t2_b_len", frm_len, 16'd8);
        chk("t2_drop_after", drop_cnt, 16'd1);
        pop_frame(8, 8'h50, "t2_b");

        // Stall mid-payload aborts the frame and rewinds the write pointer.
        do_reset();
        send_bytes(16'd14, 32'h0B00_0001, 16'd1, 8'h30, 3);
        hits = 0;
        seen_at = 0;
        for (int k = 1; k <= int'(TIMEOUT) + 4; k++) begin
            tick();
            if (abort_pulse) begin
                hits++;
                if (seen_at == 0) seen_at = k;
            end
        end
        chk("t3_abort_cycle", seen_at, TIMEOUT);
        chk("t3_abort_width", hits, 1);
        chk("t3_no_desc", frm_valid, 1'b0);
        send_bytes(16'd14, 32'h0B00_0002, 16'd2, 8'h60, 6);
        idle(1);
        chk("t3_len", frm_len, 16'd6);
        pop_frame(6, 8'h60, "t3_next");
        send_bytes(16'd24, 32'h0B00_0003, 16'd3, 8'h80, 16);
        idle(1);
        chk("t3_full_len", frm_len, 16'd16);
        chk("t3_full_drop", drop_cnt, 16'd0);
        pop_frame(16, 8'h80, "t3_full");

        // Descriptor FIFO full: third back-to-back frame dropped.
        do_reset();
        send_bytes(16'd10, 32'h0C00_0001, 16'd7, 8'h10, 6);
        idle(1);
        chk("t4_drop_cnt", drop_cnt, 16'd1);
        chk("t4_len", frm_len, 16'd2);
        pop_frame(2, 8'h10, "t4_f1");
        chk("t4_second_valid", frm_valid, 1'b1);
        pop_frame(2, 8'h12, "t4_f2");
        chk("t4_empty", frm_valid, 1'b0);

        // Bad lengths: dropped, no abort, recover on timeout.
        do_reset();
        hits = 0;
        send_bytes(16'd8, 32'h0D00_0001, 16'd9, 8'hE0, 1);
        for (int k = 0; k < int'(TIMEOUT) + 2; k++) begin
            tick();
            if (abort_pulse) hits++;
        end
        send_bytes(16'd5, 32'h0D00_0002, 16'd9, 8'hE1, 1);
        for (int k = 0; k < int'(TIMEOUT) + 2; k++) begin
            tick();
            if (abort_pulse) hits++;
        end
        chk("t5_drop_cnt", drop_cnt, 16'd2);
        chk("t5_no_abort", hits, 0);
        chk("t5_no_frame", frm_valid, 1'b0);
        send_bytes(16'd11, 32'h0D00_0003, 16'd9, 8'hC0, 3);
        idle(1);
        chk("t5_len", frm_len, 16'd3);
        pop_frame(3, 8'hC0, "t5_after");

        // Reset during S_WRITE with a committed frame pending.
        do_reset();
        send_bytes(16'd6, 32'h0E00_0001, 16'd4, 8'hF0, 1);
        idle(TIMEOUT + 2);
        send_bytes(16'd10, 32'h0E00_0002, 16'd5, 8'hA1, 2);
        idle(1);
        pop_frame(1, 8'hA1, "t6_pre");
        send_bytes(16'd20, 32'h0E00_0003, 16'd6, 8'hB0, 3);
        do_reset();
        chk("t6_frm_valid", frm_valid, 1'b0);
        chk("t6_frm_len", frm_len, 16'd0);
        chk("t6_src_addr", frm_src_addr, 32'd0);
        chk("t6_src_port", frm_src_port, 16'd0);
        chk("t6_rd_data", rd_data, 8'd0);
        chk("t6_rd_vld", rd_vld, 1'b0);
        chk("t6_drop_cnt", drop_cnt, 16'd0);
        chk("t6_abort", abort_pulse, 1'b0);
        send_bytes(16'd11, 32'h0E00_0004, 16'd7, 8'h21, 3);
        idle(1);
        chk("t6_len", frm_len, 16'd3);
        pop_frame(3, 8'h21, "t6_after");

        // Randomized frames with random consumer reads, checked by the model.
        do_reset();
        rand_rd = 1'b1;
        for (int f = 0; f < 300; f++) begin
            kind = $urandom_range(0, 9);
            rx_udp_len = 16'd8;
            rx_src_addr = $urandom;
            rx_src_port = 16'($urandom);
            if (kind == 0) begin
                rx_udp_len = 16'($urandom_range(0, 8));
                nb = $urandom_range(1, 3);
                plen = 0;
            end else if (kind == 1) begin
                plen = $urandom_range(2, 12);
                nb = $urandom_range(1, plen - 1);
            end else begin
                plen = ($urandom_range(0, 7) == 0) ? 16 : $urandom_range(1, 14);
                nb = plen;
            end
            if (kind != 0) rx_udp_len = 16'(plen + 8);
            for (int b = 0; b < nb; b++) begin
                rx_update = 1'b1;
                rx_data = 8'($urandom);
                tick();
                rx_update = 1'b0;
                if ($urandom_range(0, 5) == 0) repeat ($urandom_range(1, 3)) tick();
            end
            rx_update = 1'b0;
            if (kind <= 1) repeat (TIMEOUT + 2) tick();
            else repeat ($urandom_range(0, 2)) tick();
        end
        rand_rd = 1'b0;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/udp_rx_frame_ctrl.md
Name: udp_rx_frame_ctrl

Overview:
Frame controller behind the UDP receiver.
- Takes the receiver's per-byte payload strobe and its header fields, and stores accepted payloads in a byte ring buffer.
- Commits a descriptor (length, source IP, source port) when a frame completes.
- Hands frames to one consumer through a valid/pop interface.
- Drops frames that do not fit, and aborts frames that stall mid-payload.

Parameters:
AW, 11, ring buffer address width; buffer depth = 2**AW bytes.
TIMEOUT, 1024, idle cycles without rx_update mid-frame before the frame is aborted.

Ports:
clk  in  1  system clock
rst  in  1  reset: one clock; reset is synchronous and active-high
rx_update  in  1  payload byte strobe from UDP receiver
rx_data  in  8  payload byte, valid with rx_update
rx_udp_len  in  16  UDP length field (includes 8-byte UDP header); stable during payload
rx_src_addr  in  32  source IP; stable during payload
rx_src_port  in  16  source UDP port; stable during payload
frm_valid  out  1  a committed frame is available at the descriptor head
frm_len  out  16  payload byte count of the head frame
frm_src_addr  out  32  source IP of the head frame
frm_src_port  out  16  source port of the head frame
rd_en  in  1  pop one payload byte of the head frame
rd_data  out  8  popped byte, registered
rd_vld  out  1  rd_data valid, one cycle after an accepted rd_en
drop_cnt  out  16  frames dropped for lack of space or bad length; saturates at 16'hFFFF
abort_pulse  out  1  one-cycle pulse when a frame is aborted on timeout

Behaviour:
- Reset (rst high at a clk edge) clears all outputs to 0, wptr, rptr, used, descriptor count and gap counter. Any in-flight frame is discarded. RAM contents are don't-care.
- Payload length: plen = rx_udp_len - 8, computed in 16 bits. A frame with rx_udp_len < 9 or plen > 2**AW is a bad-length frame.
- State S_IDLE:
  - The first rx_update starts a frame and captures plen, rx_src_addr and rx_src_port.
  - Accept if the frame is not bad-length, plen <= (2**AW - used) and descriptor count < 2. Record frame start wptr, write the byte, byte count = 1, go to S_WRITE.
  - Otherwise drop_cnt++ and go to S_DROP.
  - If plen == 1, go directly to S_COMMIT (or S_IDLE when dropped).
- State S_WRITE:
  - Each rx_update writes rx_data at wptr; wptr wraps modulo 2**AW; used++; count++.
  - When count reaches plen, go to S_COMMIT.
- State S_DROP:
  - Count rx_update bytes without writing.
  - Return to S_IDLE when count reaches plen, or on timeout. A drop timeout does not pulse abort_pulse.
  - If the frame is bad-length, consume up to 2**AW bytes and then rely on timeout.
- State S_COMMIT:
  - Push a descriptor {plen, src_addr, src_port} into the 2-entry descriptor FIFO, then go to S_IDLE.
  - An rx_update arriving in S_COMMIT is treated as the next frame's first byte, evaluated as in S_IDLE.
- Timeout:
  - The gap counter resets on every rx_update and counts in S_WRITE and S_DROP.
  - When it reaches TIMEOUT in S_WRITE: restore wptr to frame start, subtract the written count from used, pulse abort_pulse for 1 cycle, go to S_IDLE. No descriptor is pushed.
- Read side:
  - frm_valid = descriptor count > 0; frm_* come from the head entry and are combinational from registers.
  - rd_en with frm_valid: RAM read at rptr, rptr wraps, used--, remaining-- (remaining loads frm_len when a descriptor becomes head). rd_data and rd_vld follow on the next cycle.
  - rd_en without frm_valid is ignored.
  - The pop of the last byte retires the head descriptor on the same edge. The next frm_valid/frm_* are visible the following cycle.
- A simultaneous write and read in one cycle updates used by +1 - 1 = 0.
- A simultaneous commit and retire leaves the descriptor count unchanged.
- The RAM is simple dual-port: 1 write and 1 read port, synchronous read. A same-address write and read cannot occur, because a read never passes the committed boundary.

Decomposition:
- Package udp_rx_pkg holds:
  - state encodings S_IDLE/S_WRITE/S_DROP/S_COMMIT
  - UDP_HDR_LEN = 8
  - DESC_DEPTH = 2
  - the descriptor field widths
- One sub-module, udp_rx_buf_ram: 2**AW x 8 simple dual-port RAM with registered read.

Test Plan:
- rx_udp_len=12, 4 rx_update bytes 11,22,33,44 from 192.168.0.5:5000 -> frm_valid=1, frm_len=4, src fields match; 4 rd_en give rd_data 11,22,33,44 with rd_vld one cycle later; frm_valid=0 after the last pop.
- AW=4, 16-byte buffer. Frame A plen=10 unread, then frame B plen=8 -> B dropped, drop_cnt=1, A intact. Pop A fully, then B' plen=8 -> accepted; the write wraps across address 15->0 and B' reads back correctly.
- Frame plen=6, 3 bytes then no rx_update for TIMEOUT cycles -> abort_pulse 1 cycle, used back to 0, no descriptor. The next 6-byte frame is stored starting at the old frame-start address.
- Three back-to-back 2-byte frames without reads -> first two committed (descriptor count 2); the third is dropped with drop_cnt=1 even though buffer space is free.
- rx_udp_len=8 and rx_udp_len=5 starting frames -> both dropped, drop_cnt=2, no RAM writes, return to S_IDLE on timeout.
- Assert rst mid-S_WRITE with one frame committed -> next cycle all outputs 0, frm_valid=0, used=0; a following 3-byte frame is received normally.
